// File: rtl/sa_batch_feeder_pkg.sv
// Shared types and sizing helpers for the matrix batch feeder.
package sa_batch_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_DRAIN,
    ST_WAIT,
    ST_DONE
  } feed_state_t;

  // Rows sent per batch; DAT_D is expected to divide evenly by N_BATCH.
  function automatic int unsigned rows_per_batch(input int unsigned dat_d,
                                                 input int unsigned n_batch);
    return dat_d / n_batch;
  endfunction

  // Width able to hold 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sa_batch_feeder_cnt.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module sa_batch_feeder_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sa_batch_feeder.sv
// Streams a row-major matrix from a 1-cycle sync-read RAM into comb_SA in
// N_BATCH equal batches, collecting the AND of the per-batch r_A_and flags.
module sa_batch_feeder
  import sa_batch_feeder_pkg::*;
#(
  parameter int unsigned DAT_W    = 8,
  parameter int unsigned DAT_D    = 12,
  parameter int unsigned N_BATCH  = 3,
  parameter int unsigned GAP      = 10,
  parameter int unsigned WAIT_FIN = 1,
  parameter int unsigned ADDR_W   = $clog2(DAT_D)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              rank_ok,
  output logic              fin_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [DAT_W-1:0]  mem_q,
  output logic              sa_start,
  output logic [DAT_W-1:0]  sa_data,
  output logic              sa_valid,
  input  logic              sa_finish,
  input  logic              sa_r_and
);

  localparam int unsigned ROWS  = rows_per_batch(DAT_D, N_BATCH);
  localparam int unsigned ROW_W = cnt_width(ROWS);
  localparam int unsigned GAP_W = cnt_width(GAP);
  localparam int unsigned BAT_W = (N_BATCH < 2) ? 1 : $clog2(N_BATCH);

  localparam logic [ROW_W-1:0]  ROW_LOAD   = ROW_W'(ROWS - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(GAP - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROWS_A     = ADDR_W'(ROWS);
  localparam logic [ADDR_W-1:0] FIRST_LAST = ADDR_W'(ROWS - 1);
  localparam logic [BAT_W-1:0]  BAT_ONE    = BAT_W'(1);
  localparam logic [BAT_W-1:0]  LAST_BATCH = BAT_W'(N_BATCH - 1);

  feed_state_t       state;
  feed_state_t       state_nxt;
  logic [BAT_W-1:0]  batch;
  logic [ADDR_W-1:0] last_addr;

  logic row_load;
  logic row_dec;
  logic row_zero;
  logic gap_load;
  logic gap_dec;
  logic gap_zero;
  logic wait_end;

  // Rows remaining in the current batch.
  sa_batch_feeder_cnt #(
    .CNT_W(ROW_W)
  ) u_row_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (row_load),
    .load_val (ROW_LOAD),
    .dec      (row_dec),
    .zero     (row_zero)
  );

  // Idle cycles remaining between batches when not waiting on sa_finish.
  sa_batch_feeder_cnt #(
    .CNT_W(GAP_W)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter control.
  // The gap count covers DRAIN plus WAIT, so WAIT_FIN=0 gives GAP+1 cycles
  // without sa_valid between the last row of one batch and the next first row.
  always_comb begin
    state_nxt = state;
    row_load  = 1'b0;
    row_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    wait_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = ST_PRIME;
        end
      end
      ST_PRIME: begin
        row_load  = 1'b1;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (row_zero) begin
          gap_load  = 1'b1;
          state_nxt = ST_DRAIN;
        end else begin
          row_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        gap_dec   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (WAIT_FIN != 0) begin
          wait_end = sa_finish;
        end else begin
          wait_end = gap_zero;
          gap_dec  = 1'b1;
        end
        if (wait_end) begin
          state_nxt = (batch == LAST_BATCH) ? ST_DONE : ST_PRIME;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read address, stream data path, batch index and run status flags.
  // Reads run one cycle ahead of the captured row; the read of the batch's
  // last address drops rden so nothing past that address is fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_rden  <= 1'b0;
      sa_data   <= '0;
      sa_valid  <= 1'b0;
      sa_start  <= 1'b0;
      batch     <= '0;
      last_addr <= '0;
      rank_ok   <= 1'b1;
      fin_err   <= 1'b0;
    end else begin
      sa_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            mem_addr  <= '0;
            mem_rden  <= 1'b1;
            batch     <= '0;
            last_addr <= FIRST_LAST;
            rank_ok   <= 1'b1;
            fin_err   <= 1'b0;
          end
        end
        ST_PRIME, ST_STREAM: begin
          if (mem_rden) begin
            if (mem_addr == last_addr) begin
              mem_rden <= 1'b0;
            end else begin
              mem_addr <= mem_addr + ADDR_ONE;
            end
          end
          if (state == ST_STREAM) begin
            sa_data  <= mem_q;
            sa_valid <= 1'b1;
            sa_start <= ~sa_valid;
          end
          if (sa_finish) begin
            fin_err <= 1'b1;
          end
        end
        ST_DRAIN: begin
          sa_valid <= 1'b0;
        end
        ST_WAIT: begin
          if (wait_end) begin
            rank_ok <= rank_ok & sa_r_and;
            if (batch != LAST_BATCH) begin
              batch     <= batch + BAT_ONE;
              mem_rden  <= 1'b1;
              mem_addr  <= last_addr + ADDR_ONE;
              last_addr <= last_addr + ROWS_A;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sa_batch_feeder.sv
// Bench for sa_batch_feeder: one instance per gap mode, each with its own RAM.
module tb_sa_batch_feeder;

  localparam int DW   = 8;
  localparam int DD   = 12;
  localparam int NB   = 3;
  localparam int RW   = DD / NB;
  localparam int GP   = 10;
  localparam int AW   = 4;
  localparam int MAXN = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [1:0]             go, busy, done, rank_ok, fin_err, rden, start, valid, fin, r_and;
  logic [1:0][AW-1:0]     addr;
  logic [1:0][DW-1:0]     q, data;
  logic [DW-1:0]          ram [2][DD];

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  int n_rows [2];
  int n_start[2];
  int n_read [2];
  int n_done [2];
  logic [DW-1:0] row_val [2][MAXN];
  int row_cyc  [2][MAXN];
  int start_cyc[2][MAXN];
  int read_addr[2][MAXN];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sa_batch_feeder #(
      .DAT_W   (DW),
      .DAT_D   (DD),
      .N_BATCH (NB),
      .GAP     (GP),
      .WAIT_FIN(g),
      .ADDR_W  (AW)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .go       (go[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .rank_ok  (rank_ok[g]),
      .fin_err  (fin_err[g]),
      .mem_addr (addr[g]),
      .mem_rden (rden[g]),
      .mem_q    (q[g]),
      .sa_start (start[g]),
      .sa_data  (data[g]),
      .sa_valid (valid[g]),
      .sa_finish(fin[g]),
      .sa_r_and (r_and[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAMs, one cycle latency.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rden[g]) q[g] <= (int'(addr[g]) < DD) ? ram[g][addr[g]] : 'x;
    end
  end

  // Trace recorder for rows, starts, reads and done pulses.
  initial begin
    for (int g = 0; g < 2; g++) begin
      n_rows[g] = 0; n_start[g] = 0; n_read[g] = 0; n_done[g] = 0;
    end
  end
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (valid[g] && n_rows[g] < MAXN) begin
        row_val[g][n_rows[g]] = data[g];
        row_cyc[g][n_rows[g]] = cyc;
        n_rows[g]++;
      end
      if (start[g] && n_start[g] < MAXN) begin
        start_cyc[g][n_start[g]] = cyc;
        n_start[g]++;
      end
      if (rden[g] && n_read[g] < MAXN) begin
        read_addr[g][n_read[g]] = int'(addr[g]);
        n_read[g]++;
      end
      if (done[g]) n_done[g]++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic check_reset(input int g);
    check_eq("rst_busy",    busy[g],    1'b0);
    check_eq("rst_done",    done[g],    1'b0);
    check_eq("rst_start",   start[g],   1'b0);
    check_eq("rst_valid",   valid[g],   1'b0);
    check_eq("rst_rden",    rden[g],    1'b0);
    check_eq("rst_fin_err", fin_err[g], 1'b0);
    check_eq("rst_rank_ok", rank_ok[g], 1'b1);
    check_eq("rst_addr",    addr[g],    '0);
    check_eq("rst_data",    data[g],    '0);
  endtask

  // One full run on DUT g, checked against the expected row stream,
  // batch timing, read trace and the AND of the per-batch flags.
  task automatic run_check(input int g, input bit hold_go, input bit inj_err,
                           input bit count_up, input logic [NB-1:0] flags);
    int exp_start[NB];
    int r0, s0, rd0, dn0, t, d;
    bit seen_v;
    for (int i = 0; i < DD; i++) ram[g][i] = count_up ? 8'(i + 1) : 8'($urandom);
    r0 = n_rows[g]; s0 = n_start[g]; rd0 = n_read[g]; dn0 = n_done[g];
    @(negedge clk);
    go[g] = 1'b1;
    r_and[g] = 1'b1;
    exp_start[0] = cyc + 3;
    @(negedge clk);
    if (!hold_go) go[g] = 1'b0;
    check_eq("busy_after_go", busy[g], 1'b1);
    check_eq("fin_err_cleared", fin_err[g], 1'b0);
    for (int b = 0; b < NB; b++) begin
      if (inj_err && b == 0) begin
        t = 0;
        while (!start[g] && t < 50) begin @(negedge clk); t++; end
        check_eq("start_timeout", (t >= 50) ? 1 : 0, 0);
        fin[g] = 1'b1; r_and[g] = 1'b0;
        @(negedge clk);
        fin[g] = 1'b0; r_and[g] = 1'b1;
      end
      seen_v = 1'b0; t = 0;
      while (!(seen_v && !valid[g]) && t < 100) begin
        if (valid[g]) seen_v = 1'b1;
        @(negedge clk); t++;
      end
      check_eq("batch_end_timeout", (t >= 100) ? 1 : 0, 0);
      r_and[g] = flags[b];
      if (g == 1) begin
        d = $urandom_range(1, 5);
        repeat (d - 1) @(negedge clk);
        fin[g] = 1'b1;
        if (b < NB - 1) exp_start[b + 1] = cyc + 3;
        @(negedge clk);
        fin[g] = 1'b0;
      end else if (b < NB - 1) begin
        exp_start[b + 1] = exp_start[0] + (b + 1) * (RW + GP + 1);
      end
    end
    t = 0;
    while (!done[g] && t < 100) begin @(negedge clk); t++; end
    check_eq("done_timeout", (t >= 100) ? 1 : 0, 0);
    if (hold_go) go[g] = 1'b0;
    check_eq("busy_at_done", busy[g], 1'b1);
    @(negedge clk);
    check_eq("busy_after_done", busy[g], 1'b0);
    check_eq("done_one_cycle", done[g], 1'b0);
    check_eq("rank_ok", rank_ok[g], &flags);
    check_eq("fin_err", fin_err[g], inj_err);
    repeat (20) @(negedge clk);
    check_eq("idle_busy", busy[g], 1'b0);
    check_eq("start_count", n_start[g] - s0, NB);
    check_eq("done_count", n_done[g] - dn0, 1);
    check_eq("row_count", n_rows[g] - r0, DD);
    check_eq("read_count", n_read[g] - rd0, DD);
    for (int b = 0; b < NB; b++) check_eq("start_cycle", start_cyc[g][s0 + b], exp_start[b]);
    for (int k = 0; k < DD; k++) begin
      check_eq("row_data", row_val[g][r0 + k], ram[g][k]);
      check_eq("row_cycle", row_cyc[g][r0 + k], exp_start[k / RW] + k % RW);
      check_eq("read_addr", read_addr[g][rd0 + k], k);
    end
  endtask

  // Reset during the second batch, then reset colliding with go.
  task automatic reset_mid_run();
    int t, ns;
    @(negedge clk);
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    ns = 0; t = 0;
    while (ns < 2 && t < 100) begin
      @(negedge clk); t++;
      if (start[0]) ns++;
    end
    check_eq("mid_rst_timeout", (t >= 100) ? 1 : 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset(0);
    rst = 1'b0;
    ns = n_done[0];
    repeat (5) @(negedge clk);
    check_eq("mid_rst_idle", busy[0], 1'b0);
    check_eq("mid_rst_no_done", n_done[0] - ns, 0);
    rst = 1'b1; go[0] = 1'b1;
    @(negedge clk);
    check_eq("rst_beats_go", busy[0], 1'b0);
    rst = 1'b0; go[0] = 1'b0;
    @(negedge clk);
    check_eq("rst_go_idle", busy[0], 1'b0);
  endtask

  initial begin
    rst = 1'b1; go = '0; fin = '0; r_and = '1;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < DD; i++) ram[g][i] = 8'(i + 1);
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;

    run_check(0, 1'b0, 1'b0, 1'b1, 3'b111);
    run_check(1, 1'b0, 1'b0, 1'b1, 3'b111);
    run_check(1, 1'b0, 1'b0, 1'b1, 3'b101);
    run_check(0, 1'b1, 1'b0, 1'b0, 3'($urandom));
    run_check(1, 1'b1, 1'b0, 1'b0, 3'($urandom));
    reset_mid_run();
    run_check(0, 1'b0, 1'b0, 1'b1, 3'b110);
    run_check(1, 1'b0, 1'b1, 1'b0, 3'b111);
    run_check(1, 1'b0, 1'b0, 1'b0, 3'($urandom));
    for (int i = 0; i < 3; i++) begin
      run_check(0, 1'($urandom), 1'b0, 1'b0, 3'($urandom));
      run_check(1, 1'($urandom), 1'($urandom), 1'b0, 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
